// File: rtl/lcd_8_to_32_bits_dfa_if.sv
// rtl/lcd_8_to_32_bits_dfa_if.sv - Avalon-ST 8-bit sink and 32-bit source bundle for the LCD read-back packer
// The slave modport is the packer itself; the master modport is whatever feeds and drains it.
interface lcd_8_to_32_bits_dfa_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;

  modport master (
    output in_data, in_valid, in_startofpacket, in_endofpacket, out_ready,
    input  in_ready, out_data, out_valid, out_startofpacket, out_endofpacket, out_empty
  );

  modport slave (
    input  in_data, in_valid, in_startofpacket, in_endofpacket, out_ready,
    output in_ready, out_data, out_valid, out_startofpacket, out_endofpacket, out_empty
  );
endinterface

// File: rtl/lcd_8_to_32_bits_dfa.sv
// rtl/lcd_8_to_32_bits_dfa.sv - packs an 8-bit symbol stream into big-endian 32-bit beats with framing
// Symbol 0 of a beat lands in [31:24]; short final words report unused low lanes through out_empty.
module lcd_8_to_32_bits_dfa (
  input  logic                         clk,
  input  logic                         reset_n,
  lcd_8_to_32_bits_dfa_if.slave        st,
  output logic                         protocol_error
);

  logic        init_done;
  logic [23:0] acc;
  logic [1:0]  count;
  logic        acc_sop;
  logic        in_pkt;

  logic [31:0] out_data_q;
  logic        out_valid_q;
  logic        out_sop_q;
  logic        out_eop_q;
  logic [1:0]  out_empty_q;
  logic        error_q;

  logic        in_ready_c;
  logic        accept;
  logic        restart;
  logic [1:0]  eff_count;
  logic [23:0] eff_acc;
  logic        complete;
  logic [31:0] word_next;
  logic        violation;
  logic        drain;

  always_comb begin
    in_ready_c = init_done && (!out_valid_q || st.out_ready);
    accept     = st.in_valid && in_ready_c;
    // A new SOP over a partial word abandons that word and restarts at lane 0.
    restart    = st.in_startofpacket && (count != 2'd0);
    eff_count  = restart ? 2'd0 : count;
    eff_acc    = restart ? 24'h0 : acc;
    complete   = (eff_count == 2'd3) || st.in_endofpacket;
    violation  = accept && (restart || (!in_pkt && !st.in_startofpacket));
    drain      = out_valid_q && st.out_ready;
    word_next  = 32'h0;
    case (eff_count)
      2'd0:    word_next = {st.in_data, 24'h0};
      2'd1:    word_next = {eff_acc[23:16], st.in_data, 16'h0};
      2'd2:    word_next = {eff_acc[23:8], st.in_data, 8'h0};
      default: word_next = {eff_acc, st.in_data};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_done   <= 1'b0;
      acc         <= 24'h0;
      count       <= 2'd0;
      acc_sop     <= 1'b0;
      in_pkt      <= 1'b0;
      out_data_q  <= 32'h0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= 2'd0;
      error_q     <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (violation)
        error_q <= 1'b1;
      if (accept) begin
        if (st.in_startofpacket)
          in_pkt <= 1'b1;
        if (st.in_endofpacket)
          in_pkt <= 1'b0;
      end
      if (accept && complete) begin
        out_data_q  <= word_next;
        out_valid_q <= 1'b1;
        out_sop_q   <= (eff_count == 2'd0) ? st.in_startofpacket : acc_sop;
        out_eop_q   <= st.in_endofpacket;
        out_empty_q <= 2'd3 - eff_count;
        acc         <= 24'h0;
        count       <= 2'd0;
        acc_sop     <= 1'b0;
      end else begin
        if (accept) begin
          acc   <= word_next[31:8];
          count <= eff_count + 2'd1;
          if (eff_count == 2'd0)
            acc_sop <= st.in_startofpacket;
        end
        if (drain)
          out_valid_q <= 1'b0;
      end
    end
  end

  assign st.in_ready          = in_ready_c;
  assign st.out_data          = out_data_q;
  assign st.out_valid         = out_valid_q;
  assign st.out_startofpacket = out_sop_q;
  assign st.out_endofpacket   = out_eop_q;
  assign st.out_empty         = out_empty_q;
  assign protocol_error       = error_q;

endmodule

// File: doc/lcd_8_to_32_bits_dfa.md
# lcd_8_to_32_bits_dfa

Avalon-ST data format adapter that packs an 8-bit symbol stream into 32-bit beats (4 symbols per beat), the inverse of the LCD 32-to-8 bit adapter. It sits on the read-back path from the LCD controller toward the Nios II DMA or FIFO. Packet framing is preserved: short final words are flagged through `out_empty`. Protocol violations are flagged through a sticky error bit.

## Interface
- Parameters: none. Symbol width 8, symbols per beat 4, and big-endian symbol order are fixed.
- `clk`  in  1  sole clock; all logic on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_data`  in  8  sink symbol
- `in_valid`  in  1  sink valid
- `in_ready`  out  1  sink ready; a transfer occurs when `in_valid && in_ready`
- `in_startofpacket`  in  1  first symbol of packet
- `in_endofpacket`  in  1  last symbol of packet
- `out_data`  out  32  source beat; symbol 0 in [31:24], symbol 3 in [7:0]
- `out_valid`  out  1  source valid
- `out_ready`  in  1  source ready
- `out_startofpacket`  out  1  beat holds the packet's first symbol
- `out_endofpacket`  out  1  beat holds the packet's last symbol
- `out_empty`  out  2  number of unused low-order symbols in the beat (0–3); meaningful only with `out_endofpacket`
- `protocol_error`  out  1  sticky; set on framing violation, cleared only by reset

## Operation
- Accumulator: 24-bit `acc`, 2-bit `count` (symbols held, 0–3), `acc_sop` flag.
- Output register: `out_data`, `out_startofpacket`, `out_endofpacket`, `out_empty`, `out_valid`.
- `in_ready` = `init_done && (!out_valid || out_ready)`.
  - `init_done` is 0 in reset and becomes 1 on the first `clk` edge after `reset_n` deasserts.
- On an accepted symbol with `count` < 3 and no `in_endofpacket`:
  - store the symbol at lane `count`;
  - `count` += 1;
  - if `count` was 0, latch `acc_sop` = `in_startofpacket`.
- On an accepted symbol that is the 4th (`count` == 3), or any symbol with `in_endofpacket`:
  - load the output register with {`acc` lanes, new symbol, zeros in unused lanes};
  - `out_empty` = 3 − `count`;
  - `out_endofpacket` = `in_endofpacket`;
  - `out_startofpacket` = (`count` == 0 ? `in_startofpacket` : `acc_sop`);
  - set `out_valid`, clear `count`, clear `acc`.
- Unused lanes are always driven 0.
- When `out_valid && out_ready` and no new beat is being loaded, clear `out_valid`.
- Load and drain in the same cycle is legal: output register reloads, `out_valid` stays 1.
- Framing violations:
  - `in_startofpacket` accepted while `count` != 0 (partial word from an unterminated packet): discard the partial `acc`, set `protocol_error`, treat the symbol as lane 0 of a new word.
  - Symbol accepted outside a packet (no SOP seen since the last EOP or reset): sets `protocol_error`; the symbol is still packed.
- Single-symbol packet (SOP and EOP together): one beat, `out_empty` = 3, both SOP and EOP set.

## Timing
- Reset values:
  - `in_ready` 0, `out_valid` 0, `out_data` 0, `out_startofpacket` 0, `out_endofpacket` 0, `out_empty` 0, `protocol_error` 0;
  - `count` 0, `acc` 0, `init_done` 0.
- `in_ready` rises exactly one clock edge after `reset_n` deasserts.
- Latency: the completing symbol accepted at edge n makes `out_valid` = 1 with that beat after edge n.
- Throughput: one symbol per clock; a beat every 4 clocks with continuous input.
- Backpressure:
  - `in_ready` is combinational from `out_ready` and `out_valid`; there is no combinational path from `in_valid` to `in_ready`.
  - While `out_valid && !out_ready`, all source outputs hold stable.
- Reset asserted mid-packet: partial word and pending beat are discarded immediately; no beat is emitted for them.

## Test plan
- Reset release -> `in_ready` = 0 while held in reset; `in_ready` = 1 one edge after release; all outputs 0.
- Packet of 8 symbols 0x01..0x08 (SOP on first, EOP on last), `out_ready` = 1 ->
  - beat 0x01020304 with SOP=1, EOP=0;
  - beat 0x05060708 with SOP=0, EOP=1, empty=0.
- Packet of 5 symbols 0xA0..0xA4 ->
  - beat 0xA0A1A2A3 with SOP;
  - beat 0xA4000000 with EOP, empty=3.
- Single-symbol packet 0x5A (SOP+EOP) -> one beat 0x5A000000, SOP=1, EOP=1, empty=3.
- Backpressure: `out_ready` held 0 after the first beat of a 12-symbol stream ->
  - `in_ready` drops once the 8th symbol is accepted;
  - `out_data` is held stable;
  - releasing `out_ready` yields all 3 beats in order with no loss or duplication.
- SOP 0x11, 0x22, then a new SOP 0x33 with EOP ->
  - `protocol_error` = 1;
  - single beat 0x33000000, SOP=1, EOP=1, empty=3;
  - error stays set until reset.
